mips_hazard_control: RTL and testbench

//   Pipeline control/hazard unit for the 5-stage MIPS datapath. Consumes the datapath's status outputs and drives its control inputs.
//   - Status in: IF/ID instruction, ID/EX Rs/Rt, stage-4/5 destination registers and RegWrite flags, ID equality flag.
//   - Control out: ControlOutput, HazardSel, PCWrite, IF_IDWrite, PCSrc, forwarding selects.
//   - Handles main decode, EX forwarding, load-use stalls, ID-stage branch stalls and branch/jump squash.

---
 rtl/mips_hazard_control.sv | 184 ++++++++++++++++++
 tb/tb_mips_hazard_control.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_control.sv
// Control/hazard unit for the 5-stage MIPS pipeline: decode, EX forwarding, load-use and ID-branch
// stalls, branch/jump squash. Define HAZARD_STATS_EN to add saturating stall/flush counters.
module mips_hazard_control #(
  parameter int CNT_W           = 16,
  parameter bit BRANCH_WB_STALL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             EqualFlag,
  input  logic [4:0]       RSReg,
  input  logic [4:0]       RTReg,
  input  logic [4:0]       RDRegStage4,
  input  logic [4:0]       RDRegStage5,
  input  logic             WriteRegSignalStage4,
  input  logic             WriteRegSignalStage5,
  output logic [8:0]       ControlOutput,
  output logic             HazardSel,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ForwardingSelA,
  output logic [1:0]       ForwardingSelB
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t state, next_state;

  logic [5:0] op, funct;
  logic [4:0] rs_id, rt_id, rd_id;
  logic       unused_shamt;

  assign op           = instruction[31:26];
  assign rs_id        = instruction[25:21];
  assign rt_id        = instruction[20:16];
  assign rd_id        = instruction[15:11];
  assign funct        = instruction[5:0];
  assign unused_shamt = ^instruction[10:6];

  logic [8:0] dec_ctrl;
  logic [4:0] dec_dest;
  logic       is_beq, is_j, reads_rt;
  logic       ex_memread, ex_regwrite;
  logic [4:0] ex_dest;
  logic       load_use, br_haz, rs_busy, rt_busy;

  // Bit layout: {MemRead, MemWrite, ALUSrc, RegDst, ALUop[2:0], MemtoReg, RegWrite}
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_ctrl = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_AND:   dec_ctrl = {2'b00, 1'b0, 1'b0, 3'b000, 2'b01};
          F_OR:    dec_ctrl = {2'b00, 1'b0, 1'b0, 3'b001, 2'b01};
          F_ADD:   dec_ctrl = {2'b00, 1'b0, 1'b0, 3'b010, 2'b01};
          F_SUB:   dec_ctrl = {2'b00, 1'b0, 1'b0, 3'b110, 2'b01};
          F_SLT:   dec_ctrl = {2'b00, 1'b0, 1'b0, 3'b111, 2'b01};
          default: dec_ctrl = '0;
        endcase
      end
      OP_LW:   dec_ctrl = {2'b10, 1'b1, 1'b1, 3'b010, 2'b11};
      OP_SW:   dec_ctrl = {2'b01, 1'b1, 1'b0, 3'b010, 2'b00};
      OP_ADDI: dec_ctrl = {2'b00, 1'b1, 1'b1, 3'b010, 2'b01};
      default: dec_ctrl = '0;
    endcase
  end

  assign dec_dest = dec_ctrl[5] ? rt_id : rd_id;
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign reads_rt = (op == OP_RTYPE) || (op == OP_SW) || is_beq;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic w4, input logic [4:0] d4,
                                         input logic w5, input logic [4:0] d5);
    if (src == 5'd0)           return 2'b00;
    if (w4 && (d4 == src))     return 2'b01;
    if (w5 && (d5 == src))     return 2'b10;
    return 2'b00;
  endfunction

  assign load_use = ex_memread && (ex_dest != 5'd0) &&
                    ((ex_dest == rs_id) || (reads_rt && (ex_dest == rt_id)));

  // The beq compares in ID, so any producer still ahead of writeback must drain first.
  assign rs_busy = (rs_id != 5'd0) &&
                   ((ex_regwrite && (ex_dest == rs_id)) ||
                    (WriteRegSignalStage4 && (RDRegStage4 == rs_id)) ||
                    (BRANCH_WB_STALL && WriteRegSignalStage5 && (RDRegStage5 == rs_id)));
  assign rt_busy = (rt_id != 5'd0) &&
                   ((ex_regwrite && (ex_dest == rt_id)) ||
                    (WriteRegSignalStage4 && (RDRegStage4 == rt_id)) ||
                    (BRANCH_WB_STALL && WriteRegSignalStage5 && (RDRegStage5 == rt_id)));
  assign br_haz  = is_beq && (rs_busy || rt_busy);

  always_comb begin
    next_state     = RUN;
    HazardSel      = 1'b0;
    PCWrite        = 1'b1;
    IF_IDWrite     = 1'b1;
    PCSrc          = 2'b00;
    ControlOutput  = dec_ctrl;
    ForwardingSelA = fwd_sel(RSReg, WriteRegSignalStage4, RDRegStage4,
                             WriteRegSignalStage5, RDRegStage5);
    ForwardingSelB = fwd_sel(RTReg, WriteRegSignalStage4, RDRegStage4,
                             WriteRegSignalStage5, RDRegStage5);
    if (state == FLUSH) begin
      next_state = RUN;
    end else if (load_use || br_haz) begin
      next_state = STALL;
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
    end else begin
      HazardSel = 1'b1;
      if (is_j) begin
        PCSrc      = 2'b10;
        next_state = FLUSH;
      end else if (is_beq && EqualFlag) begin
        PCSrc      = 2'b01;
        next_state = FLUSH;
      end
    end
    // Reset acts on the outputs immediately, not at the next edge.
    if (rst) begin
      next_state     = RUN;
      HazardSel      = 1'b0;
      PCWrite        = 1'b1;
      IF_IDWrite     = 1'b1;
      PCSrc          = 2'b00;
      ControlOutput  = '0;
      ForwardingSelA = 2'b00;
      ForwardingSelB = 2'b00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      ex_memread  <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_dest     <= '0;
    end else begin
      state       <= next_state;
      ex_memread  <= HazardSel & dec_ctrl[8];
      ex_regwrite <= HazardSel & dec_ctrl[0];
      ex_dest     <= HazardSel ? dec_dest : 5'd0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite && (StallCount != '1))
        StallCount <= StallCount + CNT_W'(1);
      if ((state == FLUSH) && (FlushCount != '1))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mips_hazard_control.sv
// Self-checking bench for mips_hazard_control: directed forwarding/stall/branch/jump/reset steps,
// then randomized traffic against a pipeline-level reference model. Counter checks need HAZARD_STATS_EN.
`timescale 1ns/1ps
module tb_mips_hazard_control;
  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, RTYPE = 6'b000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0;
  logic        EqualFlag = 1'b0;
  logic [4:0]  RSReg = '0, RTReg = '0, RDRegStage4 = '0, RDRegStage5 = '0;
  logic        WriteRegSignalStage4 = 1'b0, WriteRegSignalStage5 = 1'b0;

  logic [8:0]  ControlOutput;
  logic        HazardSel, PCWrite, IF_IDWrite;
  logic [1:0]  PCSrc, ForwardingSelA, ForwardingSelB;

  logic [8:0]  unused_nwb_ctrl;
  logic        unused_nwb_hs, nwb_pcwrite, unused_nwb_ifw;
  logic [1:0]  unused_nwb_pcsrc, unused_nwb_fa, unused_nwb_fb;
`ifdef HAZARD_STATS_EN
  logic [TB_CNT_W-1:0] StallCount, FlushCount, unused_nwb_sc, unused_nwb_fc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_hazard_control #(.CNT_W(TB_CNT_W), .BRANCH_WB_STALL(1'b1)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .EqualFlag(EqualFlag),
    .RSReg(RSReg), .RTReg(RTReg), .RDRegStage4(RDRegStage4), .RDRegStage5(RDRegStage5),
    .WriteRegSignalStage4(WriteRegSignalStage4), .WriteRegSignalStage5(WriteRegSignalStage5),
    .ControlOutput(ControlOutput), .HazardSel(HazardSel), .PCWrite(PCWrite),
    .IF_IDWrite(IF_IDWrite), .PCSrc(PCSrc),
    .ForwardingSelA(ForwardingSelA), .ForwardingSelB(ForwardingSelB)
`ifdef HAZARD_STATS_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  // Same inputs, no writeback-stage branch check: used to compare stall lengths.
  mips_hazard_control #(.CNT_W(TB_CNT_W), .BRANCH_WB_STALL(1'b0)) dut_nwb (
    .clk(clk), .rst(rst), .instruction(instruction), .EqualFlag(EqualFlag),
    .RSReg(RSReg), .RTReg(RTReg), .RDRegStage4(RDRegStage4), .RDRegStage5(RDRegStage5),
    .WriteRegSignalStage4(WriteRegSignalStage4), .WriteRegSignalStage5(WriteRegSignalStage5),
    .ControlOutput(unused_nwb_ctrl), .HazardSel(unused_nwb_hs), .PCWrite(nwb_pcwrite),
    .IF_IDWrite(unused_nwb_ifw), .PCSrc(unused_nwb_pcsrc),
    .ForwardingSelA(unused_nwb_fa), .ForwardingSelB(unused_nwb_fb)
`ifdef HAZARD_STATS_EN
    , .StallCount(unused_nwb_sc), .FlushCount(unused_nwb_fc)
`endif
  );

  // Reference model: what occupies EX, whether ID holds a squashed instruction, counters.
  bit         m_flush, m_ex_load, m_ex_writes;
  logic [4:0] m_ex_dest;
  int         m_stalls, m_flushes;

  logic [8:0] e_ctrl;
  logic       e_hs, e_pcw, e_ifw, e_next_flush;
  logic [1:0] e_pcsrc, e_fa, e_fb;
  logic [4:0] e_dest;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [8:0] ref_ctrl(input logic [31:0] ins);
    case (ins[31:26])
      RTYPE: case (ins[5:0])
               6'b100100: return 9'b00_0_0_000_01;
               6'b100101: return 9'b00_0_0_001_01;
               6'b100000: return 9'b00_0_0_010_01;
               6'b100010: return 9'b00_0_0_110_01;
               6'b101010: return 9'b00_0_0_111_01;
               default:   return 9'b0;
             endcase
      LW:      return 9'b10_1_1_010_11;
      SW:      return 9'b01_1_0_010_00;
      ADDI:    return 9'b00_1_1_010_01;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (WriteRegSignalStage4 && RDRegStage4 == r) return 2'b01;
    if (WriteRegSignalStage5 && RDRegStage5 == r) return 2'b10;
    return 2'b00;
  endfunction

  // A register is unavailable to an ID-stage compare while any older writer has not retired.
  function automatic bit ref_busy(input logic [4:0] r);
    if (r == 0) return 1'b0;
    return (m_ex_writes && m_ex_dest == r) ||
           (WriteRegSignalStage4 && RDRegStage4 == r) ||
           (WriteRegSignalStage5 && RDRegStage5 == r);
  endfunction

  task automatic model_eval();
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit lu, bh, uses_rt;
    op = instruction[31:26];
    rs = instruction[25:21];
    rt = instruction[20:16];
    e_ctrl = ref_ctrl(instruction);
    e_dest = (op == LW || op == ADDI) ? rt : instruction[15:11];
    e_fa = ref_fwd(RSReg);
    e_fb = ref_fwd(RTReg);
    e_next_flush = 1'b0;
    e_pcsrc = 2'b00;
    if (rst) begin
      e_ctrl = '0; e_hs = 0; e_pcw = 1; e_ifw = 1; e_fa = 0; e_fb = 0;
      return;
    end
    uses_rt = (op == RTYPE) || (op == SW) || (op == BEQ);
    lu = m_ex_load && m_ex_dest != 0 && (m_ex_dest == rs || (uses_rt && m_ex_dest == rt));
    bh = (op == BEQ) && (ref_busy(rs) || ref_busy(rt));
    if (m_flush) begin
      e_hs = 0; e_pcw = 1; e_ifw = 1;
    end else if (lu || bh) begin
      e_hs = 0; e_pcw = 0; e_ifw = 0;
    end else begin
      e_hs = 1; e_pcw = 1; e_ifw = 1;
      if (op == JMP) e_pcsrc = 2'b10;
      else if (op == BEQ && EqualFlag) e_pcsrc = 2'b01;
      e_next_flush = (e_pcsrc != 2'b00);
    end
  endtask

  task automatic model_step();
    if (!e_pcw && m_stalls < CNT_MAX) m_stalls++;
    if (m_flush && m_flushes < CNT_MAX) m_flushes++;
    m_ex_load   = e_hs && instruction[31:26] == LW;
    m_ex_writes = e_hs && e_ctrl[0];
    m_ex_dest   = e_hs ? e_dest : 5'd0;
    m_flush     = e_next_flush;
  endtask

  task automatic model_clear();
    m_flush = 0; m_ex_load = 0; m_ex_writes = 0; m_ex_dest = '0;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic clear_inputs();
    instruction = '0; EqualFlag = 0; RSReg = '0; RTReg = '0;
    RDRegStage4 = '0; RDRegStage5 = '0;
    WriteRegSignalStage4 = 0; WriteRegSignalStage5 = 0;
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    check({tag, ".ctrl"}, 32'(ControlOutput), 32'(e_ctrl));
    check({tag, ".hazsel"}, 32'(HazardSel), 32'(e_hs));
    check({tag, ".pcwrite"}, 32'(PCWrite), 32'(e_pcw));
    check({tag, ".ifidwrite"}, 32'(IF_IDWrite), 32'(e_ifw));
    check({tag, ".pcsrc"}, 32'(PCSrc), 32'(e_pcsrc));
    check({tag, ".fwd_a"}, 32'(ForwardingSelA), 32'(e_fa));
    check({tag, ".fwd_b"}, 32'(ForwardingSelB), 32'(e_fb));
`ifdef HAZARD_STATS_EN
    check({tag, ".stall_cnt"}, 32'(StallCount), 32'(m_stalls));
    check({tag, ".flush_cnt"}, 32'(FlushCount), 32'(m_flushes));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_clear();
    sample("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5];
    int a, b, c;
    fns = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
    a = int'($urandom_range(0, 3));
    b = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    case ($urandom_range(0, 8))
      0, 1:    return rtype(fns[$urandom_range(0, 4)], a, b, c);
      2:       return itype(LW, a, b, 0);
      3:       return itype(SW, a, b, 4);
      4:       return itype(ADDI, a, b, 1);
      5, 6:    return itype(BEQ, a, b, 2);
      7:       return {JMP, 26'h10};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int nwb_stalls, wb_stalls;
    do_reset();

    // T1: forwarding priority and $0 exclusion
    RSReg = 5; RDRegStage4 = 5; WriteRegSignalStage4 = 1;
    RTReg = 7; RDRegStage5 = 7; WriteRegSignalStage5 = 1;
    sample("t1_fwd");
    check("t1_fwd_a_ex", 32'(ForwardingSelA), 32'd1);
    check("t1_fwd_b_wb", 32'(ForwardingSelB), 32'd2);
    tick();
    RDRegStage5 = 5;
    sample("t1_both");
    check("t1_stage4_wins", 32'(ForwardingSelA), 32'd1);
    tick();
    RSReg = 0; RDRegStage4 = 0;
    sample("t1_zero");
    check("t1_zero_reg", 32'(ForwardingSelA), 32'd0);
    tick();

    // T2: lw $3,0($1) then add $4,$3,$2
    clear_inputs();
    instruction = itype(LW, 1, 3, 0);
    sample("t2_lw");
    tick();
    instruction = rtype(6'b100000, 3, 2, 4);
    sample("t2_stall");
    check("t2_stall_pcw", 32'(PCWrite), 32'd0);
    check("t2_stall_ifw", 32'(IF_IDWrite), 32'd0);
    check("t2_stall_hs", 32'(HazardSel), 32'd0);
    tick();
    RDRegStage4 = 3; WriteRegSignalStage4 = 1;
    sample("t2_go");
    check("t2_go_ctrl", 32'(ControlOutput), 32'h009);
    check("t2_go_hs", 32'(HazardSel), 32'd1);
    tick();

    // T3: beq taken (add in EX/MEM, lw in WB, neither touches $1/$2), then untaken
    RDRegStage4 = 4; WriteRegSignalStage4 = 1; RDRegStage5 = 3; WriteRegSignalStage5 = 1;
    instruction = itype(BEQ, 1, 2, 8); EqualFlag = 1;
    sample("t3_taken");
    check("t3_taken_pcsrc", 32'(PCSrc), 32'd1);
    tick();
    clear_inputs();
    instruction = rtype(6'b100000, 6, 7, 5);
    sample("t3_flush");
    check("t3_flush_hs", 32'(HazardSel), 32'd0);
    check("t3_flush_pcsrc", 32'(PCSrc), 32'd0);
    check("t3_flush_pcw", 32'(PCWrite), 32'd1);
    tick();
    instruction = itype(BEQ, 1, 2, 8); EqualFlag = 0;
    sample("t3_untaken");
    check("t3_untaken_pcsrc", 32'(PCSrc), 32'd0);
    tick();
    instruction = '0;
    sample("t3_noflush");
    check("t3_noflush_hs", 32'(HazardSel), 32'd1);
    tick();
`ifdef HAZARD_STATS_EN
    check("t6_stall_count", 32'(StallCount), 32'd1);
    check("t6_flush_count", 32'(FlushCount), 32'd1);
`endif

    // T4: addi $2,$0,1 directly before beq $2,$0 (held in ID while stalled)
    do_reset();
    instruction = itype(ADDI, 0, 2, 1);
    sample("t4_addi");
    tick();
    instruction = itype(BEQ, 2, 0, 4);
    wb_stalls = 0; nwb_stalls = 0;
    for (int k = 1; k <= 5; k++) begin
      RDRegStage4 = (k == 2) ? 5'd2 : 5'd0; WriteRegSignalStage4 = (k == 2);
      RDRegStage5 = (k == 3) ? 5'd2 : 5'd0; WriteRegSignalStage5 = (k == 3);
      sample("t4_beq");
      if (!PCWrite) wb_stalls++;
      if (!nwb_pcwrite) nwb_stalls++;
      tick();
    end
    check("t4_stalls_wb", 32'(wb_stalls), 32'd3);
    check("t4_stalls_nowb", 32'(nwb_stalls), 32'd2);

    // T5: jump squash, then reset asserted while stalled
    do_reset();
    instruction = {JMP, 26'h10};
    sample("t5_jump");
    check("t5_jump_pcsrc", 32'(PCSrc), 32'd2);
    tick();
    instruction = rtype(6'b100000, 1, 1, 1);
    sample("t5_flush");
    check("t5_flush_hs", 32'(HazardSel), 32'd0);
    tick();
    instruction = itype(ADDI, 0, 2, 1);
    sample("t5_addi");
    tick();
    instruction = itype(BEQ, 2, 0, 4);
    sample("t5_stall1");
    tick();
    RSReg = 2; RDRegStage4 = 2; WriteRegSignalStage4 = 1;
    sample("t5_stall2");
    check("t5_in_stall", 32'(PCWrite), 32'd0);
    #2;
    rst = 1'b1;
    instruction = itype(LW, 1, 3, 0);
    #1;
    check("t5_rst_pcw", 32'(PCWrite), 32'd1);
    check("t5_rst_ifw", 32'(IF_IDWrite), 32'd1);
    check("t5_rst_hs", 32'(HazardSel), 32'd0);
    check("t5_rst_ctrl", 32'(ControlOutput), 32'd0);
    check("t5_rst_pcsrc", 32'(PCSrc), 32'd0);
    check("t5_rst_fwd_a", 32'(ForwardingSelA), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    instruction = itype(BEQ, 2, 0, 4);
    sample("t5_after");
    check("t5_after_hs", 32'(HazardSel), 32'd1);
    check("t5_after_pcw", 32'(PCWrite), 32'd1);
    tick();

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      instruction = rand_instr();
      EqualFlag = 1'($urandom_range(0, 1));
      RSReg = 5'($urandom_range(0, 3));
      RTReg = 5'($urandom_range(0, 3));
      RDRegStage4 = 5'($urandom_range(0, 3));
      RDRegStage5 = 5'($urandom_range(0, 3));
      WriteRegSignalStage4 = 1'($urandom_range(0, 1));
      WriteRegSignalStage5 = 1'($urandom_range(0, 1));
      sample("rnd");
      tick();
    end
`ifdef HAZARD_STATS_EN
    check("t6_stall_saturated", 32'(StallCount), 32'(CNT_MAX));
    check("t6_flush_saturated", 32'(FlushCount), 32'(CNT_MAX));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
